// File: rtl/uintarith_pkg.sv
// rtl/uintarith_pkg.sv - shared widths and state encoding for the unsigned arithmetic blocks
package uintarith_pkg;

  localparam int DIVIDEND_W_DEF = 16;
  localparam int DIVISOR_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/uintdiv_step.sv
// rtl/uintdiv_step.sv - one combinational restoring-division step
module uintdiv_step #(
  parameter int DIVISOR_W = 8
) (
  input  logic [DIVISOR_W:0]   r_i,
  input  logic                 q_msb_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W:0]   r_o,
  output logic                 q_bit_o
);

  logic [DIVISOR_W+1:0] shifted;
  logic [DIVISOR_W+1:0] trial;

  // One extra bit above the partial remainder carries the trial sign.
  always_comb begin
    shifted = {r_i, q_msb_i};
    trial   = shifted - {2'b00, divisor_i};
    q_bit_o = ~trial[DIVISOR_W+1];
    r_o     = q_bit_o ? trial[DIVISOR_W:0] : shifted[DIVISOR_W:0];
  end

endmodule

// File: rtl/uintdiv16.sv
// rtl/uintdiv16.sv - sequential radix-2 restoring divider with valid/ready handshakes
module uintdiv16
  import uintarith_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF,
  parameter int CNT_W      = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

  div_state_e            state_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [DIVIDEND_W-1:0] quotient_q;
  logic [DIVISOR_W-1:0]  remainder_q;
  logic                  div_by_zero_q;
  logic [DIVISOR_W-1:0]  divisor_q;
  logic [DIVIDEND_W-1:0] q_q;
  logic [DIVISOR_W:0]    r_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  dbz_pend_q;

  logic [DIVISOR_W:0]    r_d;
  logic                  q_bit_d;

  uintdiv_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .r_i       (r_q),
    .q_msb_i   (q_q[DIVIDEND_W-1]),
    .divisor_i (divisor_q),
    .r_o       (r_d),
    .q_bit_o   (q_bit_d)
  );

  // DONE spends its first cycle publishing the result, so the outputs
  // only ever change together with the rising edge of out_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      divisor_q     <= '0;
      q_q           <= '0;
      r_q           <= '0;
      cnt_q         <= '0;
      dbz_pend_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            divisor_q  <= divisor;
            cnt_q      <= '0;
            if (divisor == '0) begin
              state_q    <= DONE;
              q_q        <= '1;
              r_q        <= {1'b0, dividend[DIVISOR_W-1:0]};
              dbz_pend_q <= 1'b1;
            end else begin
              state_q    <= CALC;
              q_q        <= dividend;
              r_q        <= '0;
              dbz_pend_q <= 1'b0;
            end
          end
        end
        CALC: begin
          r_q   <= r_d;
          q_q   <= {q_q[DIVIDEND_W-2:0], q_bit_d};
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q   <= 1'b1;
            quotient_q    <= q_q;
            remainder_q   <= r_q[DIVISOR_W-1:0];
            div_by_zero_q <= dbz_pend_q;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_uintdiv16.sv
// tb/tb_uintdiv16.sv - self-checking bench for uintdiv16
module tb_uintdiv16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  uintdiv16 dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    bit          dbz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Submit one operation, wait for its result, optionally stall the
  // consumer for `hold` cycles, then complete the output handshake.
  task automatic do_div(input logic [15:0] a, input logic [7:0] b, input int hold,
                        input bit garbage,
                        output logic [15:0] q, output logic [7:0] r, output bit dbz,
                        output int lat, output bit busy_ok, output bit stable_ok);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    if (!in_ready) check("in_ready_wait", 0, 1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    if (garbage) begin
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    lat = 0;
    busy_ok = 1'b1;
    while (!out_valid && lat < 60) begin
      if (in_ready) busy_ok = 1'b0;
      tick();
      lat++;
    end
    q = quotient;
    r = remainder;
    dbz = div_by_zero;
    stable_ok = 1'b1;
    repeat (hold) begin
      if (in_ready) busy_ok = 1'b0;
      tick();
      if (!out_valid || quotient !== q || remainder !== r || div_by_zero !== dbz)
        stable_ok = 1'b0;
    end
    if (in_ready) busy_ok = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                output logic [15:0] q, output logic [7:0] r,
                                output bit dbz, output int lat);
    if (b == 0) begin
      q = 16'hFFFF;
      r = a[7:0];
      dbz = 1'b1;
      lat = 1;
    end else begin
      q = 16'(int'(a) / int'(b));
      r = 8'(int'(a) % int'(b));
      dbz = 1'b0;
      lat = 17;
    end
  endfunction

  initial begin
    logic [15:0] gq, eq;
    logic [7:0]  gr, er, ra, rb;
    logic [15:0] rdvd;
    bit          gdbz, edbz, busy_ok, stable_ok, quiet;
    int          glat, elat, rand_bad;

    vecs[0]  = '{16'd65025, 8'd255, 16'd255,   8'd0,   1'b0, 17};
    vecs[1]  = '{16'd1000,  8'd7,   16'd142,   8'd6,   1'b0, 17};
    vecs[2]  = '{16'd3,     8'd200, 16'd0,     8'd3,   1'b0, 17};
    vecs[3]  = '{16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0, 17};
    vecs[4]  = '{16'd65535, 8'd255, 16'd257,   8'd0,   1'b0, 17};
    vecs[5]  = '{16'd5,     8'd0,   16'hFFFF,  8'd5,   1'b1, 1};
    vecs[6]  = '{16'd50000, 8'd3,   16'd16666, 8'd2,   1'b0, 17};
    vecs[7]  = '{16'd0,     8'd0,   16'hFFFF,  8'd0,   1'b1, 1};
    vecs[8]  = '{16'd65535, 8'd0,   16'hFFFF,  8'd255, 1'b1, 1};
    vecs[9]  = '{16'd12345, 8'd100, 16'd123,   8'd45,  1'b0, 17};
    vecs[10] = '{16'd254,   8'd255, 16'd0,     8'd254, 1'b0, 17};
    vecs[11] = '{16'd0,     8'd9,   16'd0,     8'd0,   1'b0, 17};

    repeat (3) tick();
    reset = 1'b0;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_quotient", int'(quotient), 0);
    check("reset_remainder", int'(remainder), 0);
    check("reset_dbz", int'(div_by_zero), 0);

    // Back-to-back table run; entries 5 then 6 show a normal divide clearing dbz.
    for (int i = 0; i < 12; i++) begin
      do_div(vecs[i].a, vecs[i].b, 0, 1'b0, gq, gr, gdbz, glat, busy_ok, stable_ok);
      check($sformatf("vec%0d_quotient", i), int'(gq), int'(vecs[i].q));
      check($sformatf("vec%0d_remainder", i), int'(gr), int'(vecs[i].r));
      check($sformatf("vec%0d_dbz", i), int'(gdbz), int'(vecs[i].dbz));
      check($sformatf("vec%0d_latency", i), glat, vecs[i].lat);
      check($sformatf("vec%0d_busy", i), int'(busy_ok), 1);
      check($sformatf("vec%0d_post_in_ready", i), int'(in_ready), 1);
      check($sformatf("vec%0d_post_out_valid", i), int'(out_valid), 0);
    end

    // Consumer stall for ten cycles.
    do_div(16'd12345, 8'd100, 10, 1'b0, gq, gr, gdbz, glat, busy_ok, stable_ok);
    check("bp_quotient", int'(gq), 123);
    check("bp_remainder", int'(gr), 45);
    check("bp_stable", int'(stable_ok), 1);
    check("bp_busy", int'(busy_ok), 1);
    check("bp_post_in_ready", int'(in_ready), 1);

    // Operand changes and a held in_valid during CALC must be ignored.
    do_div(16'd40000, 8'd77, 2, 1'b1, gq, gr, gdbz, glat, busy_ok, stable_ok);
    check("garbage_quotient", int'(gq), 519);
    check("garbage_remainder", int'(gr), 37);
    check("garbage_busy", int'(busy_ok), 1);

    // Reset mid-CALC discards the in-flight operation.
    in_valid = 1'b1;
    dividend = 16'd50000;
    divisor  = 8'd3;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midcalc_rst_out_valid", int'(out_valid), 0);
    check("midcalc_rst_in_ready", int'(in_ready), 1);
    quiet = 1'b1;
    repeat (20) begin
      tick();
      if (out_valid) quiet = 1'b0;
    end
    check("midcalc_rst_quiet", int'(quiet), 1);
    do_div(16'd50000, 8'd3, 0, 1'b0, gq, gr, gdbz, glat, busy_ok, stable_ok);
    check("after_rst_quotient", int'(gq), 16666);
    check("after_rst_remainder", int'(gr), 2);

    // Reset while a result is waiting in DONE.
    in_valid = 1'b1;
    dividend = 16'd9;
    divisor  = 8'd0;
    tick();
    in_valid = 1'b0;
    tick();
    check("done_valid_before_rst", int'(out_valid), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("done_rst_out_valid", int'(out_valid), 0);
    check("done_rst_in_ready", int'(in_ready), 1);
    check("done_rst_dbz", int'(div_by_zero), 0);

    // Randomized operands against plain-arithmetic reference.
    rand_bad = 0;
    for (int i = 0; i < 200; i++) begin
      rdvd = 16'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      ra = rdvd[7:0];
      model(rdvd, rb, eq, er, edbz, elat);
      do_div(rdvd, rb, $urandom_range(0, 3), 1'b0, gq, gr, gdbz, glat, busy_ok, stable_ok);
      if (gq !== eq || gr !== er || gdbz !== edbz || glat != elat || !busy_ok || !stable_ok) begin
        rand_bad++;
        if (rand_bad <= 5)
          $display("FAIL rand_%0d: %0d/%0d got q=%0d r=%0d dbz=%0d lat=%0d expected q=%0d r=%0d dbz=%0d lat=%0d (low=%0d)",
                   i, rdvd, rb, gq, gr, gdbz, glat, eq, er, edbz, elat, ra);
      end
    end
    check("random_mismatches", rand_bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
